mau_stream: RTL and testbench

- Second-generation matrix arithmetic unit, parametrised in matrix dimension, element width and bank count.
- Replaces byte-strobed host access with valid/ready command, load and store channels.
- Executes element-wise operations one row per cycle instead of as one full-matrix combinational chunk.
- Sits between the host interface and the matrix register banks as the chip's compute core.

---
 rtl/mau_stream.sv | 174 +++++++++++++++++
 tb/tb_mau_stream.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mau_stream.sv
// mau_stream: streaming matrix arithmetic unit with valid/ready command, load and store channels.
// Define MAU_STREAM_SAT_EN to make ADD, SUB and MUL saturate instead of wrapping.
module mau_stream #(
    parameter int DIM   = 4,
    parameter int EW    = 8,
    parameter int BANKS = 4,
    localparam int BW   = $clog2(BANKS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic [BW-1:0] cmd_src_a,
    input  logic [BW-1:0] cmd_src_b,
    input  logic [BW-1:0] cmd_dst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [EW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [EW-1:0] out_data,
    output logic          busy,
    output logic          done
);

    localparam int NEL = DIM * DIM;
    localparam int KW  = $clog2(NEL);
    localparam int RW  = $clog2(DIM);
    localparam logic [KW-1:0] K_LAST = KW'(NEL - 1);
    localparam logic [RW-1:0] R_LAST = RW'(DIM - 1);

    typedef enum logic [2:0] {
        OP_LOAD  = 3'd0,
        OP_STORE = 3'd1,
        OP_ADD   = 3'd2,
        OP_SUB   = 3'd3,
        OP_MUL   = 3'd4,
        OP_SHL   = 3'd5,
        OP_COPY  = 3'd6,
        OP_CLEAR = 3'd7
    } op_t;

    // NOTE: one-hot states so every handshake/status output is a flop bit, not decoded logic.
    typedef enum logic [4:0] {
        S_IDLE  = 5'b00001,
        S_LOAD  = 5'b00010,
        S_STORE = 5'b00100,
        S_EXEC  = 5'b01000,
        S_DONE  = 5'b10000
    } state_t;

    typedef logic [EW-1:0] elem_t;

    state_t        state;
    op_t           op_q;
    logic [BW-1:0] src_a_q;
    logic [BW-1:0] src_b_q;
    logic [BW-1:0] dst_q;
    logic [KW-1:0] k;
    logic [RW-1:0] r;
    elem_t         out_q;
    elem_t         mem     [BANKS][NEL];
    elem_t         row_res [DIM];

    assign cmd_ready = state[0];
    assign in_ready  = state[1];
    assign out_valid = state[2];
    assign done      = state[4];
    assign busy      = ~state[0];
    assign out_data  = out_q;

    function automatic logic [KW-1:0] idx(logic [RW-1:0] row, int col);
        return KW'(int'(row) * DIM + col);
    endfunction

    function automatic elem_t alu(op_t op, elem_t a, elem_t b);
        elem_t res;
        case (op)
            OP_ADD:  res = a + b;
            OP_SUB:  res = a - b;
            OP_MUL:  res = a * b;
            OP_SHL:  res = a << (b % elem_t'(EW));
            OP_COPY: res = a;
            default: res = '0;
        endcase
`ifdef MAU_STREAM_SAT_EN
        begin : sat
            logic [2*EW-1:0] prod;
            prod = {{EW{1'b0}}, a} * {{EW{1'b0}}, b};
            // A wrapped sum is smaller than either addend exactly when it carried out.
            if (op == OP_ADD && res < a) res = '1;
            if (op == OP_SUB && a < b) res = '0;
            if (op == OP_MUL && |prod[2*EW-1:EW]) res = '1;
        end
`endif
        return res;
    endfunction

    always_comb begin
        for (int c = 0; c < DIM; c++) begin
            row_res[RW'(c)] = alu(op_q, mem[src_a_q][idx(r, c)], mem[src_b_q][idx(r, c)]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            op_q    <= OP_LOAD;
            src_a_q <= '0;
            src_b_q <= '0;
            dst_q   <= '0;
            k       <= '0;
            r       <= '0;
            out_q   <= '0;
            // NOTE: the banks must read as zero after reset, so they are flops cleared here, not a RAM.
            for (int b = 0; b < BANKS; b++) begin
                for (int e = 0; e < NEL; e++) begin
                    mem[BW'(b)][KW'(e)] <= '0;
                end
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        op_q    <= op_t'(cmd_op);
                        src_a_q <= cmd_src_a;
                        src_b_q <= cmd_src_b;
                        dst_q   <= cmd_dst;
                        k       <= '0;
                        r       <= '0;
                        case (op_t'(cmd_op))
                            OP_LOAD:  state <= S_LOAD;
                            OP_STORE: begin
                                state <= S_STORE;
                                out_q <= mem[cmd_src_a][KW'(0)];
                            end
                            default:  state <= S_EXEC;
                        endcase
                    end
                end
                S_LOAD: begin
                    if (in_valid) begin
                        mem[dst_q][k] <= in_data;
                        if (k == K_LAST) state <= S_DONE;
                        else             k     <= k + 1'b1;
                    end
                end
                S_STORE: begin
                    if (out_ready) begin
                        if (k == K_LAST) begin
                            state <= S_DONE;
                        end else begin
                            k     <= k + 1'b1;
                            out_q <= mem[src_a_q][k + 1'b1];
                        end
                    end
                end
                S_EXEC: begin
                    // NOTE: row r is read combinationally and written non-blocking, so aliased
                    // operands see the old row and in-place results match out-of-place ones.
                    for (int c = 0; c < DIM; c++) begin
                        mem[dst_q][idx(r, c)] <= row_res[RW'(c)];
                    end
                    if (r == R_LAST) state <= S_DONE;
                    else             r     <= r + 1'b1;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mau_stream.sv
// Self-checking bench for mau_stream: random handshakes against a whole-matrix reference model,
// plus a second small instance (DIM=2, EW=16, BANKS=2) for the parameter sweep.
`timescale 1ns/1ps
module tb_mau_stream;

    localparam int DIM   = 4;
    localparam int EW    = 8;
    localparam int BANKS = 4;
    localparam int NEL   = DIM * DIM;
    localparam int MAXV  = (1 << EW) - 1;

    localparam int OP_LOAD  = 0;
    localparam int OP_STORE = 1;
    localparam int OP_ADD   = 2;
    localparam int OP_SUB   = 3;
    localparam int OP_MUL   = 4;
    localparam int OP_SHL   = 5;
    localparam int OP_COPY  = 6;
    localparam int OP_CLEAR = 7;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cmd_valid, cmd_ready;
    logic [2:0]    cmd_op;
    logic [1:0]    cmd_src_a, cmd_src_b, cmd_dst;
    logic          in_valid, in_ready;
    logic [EW-1:0] in_data;
    logic          out_valid, out_ready;
    logic [EW-1:0] out_data;
    logic          busy, done;

    logic          cmd_valid2, cmd_ready2;
    logic [2:0]    cmd_op2;
    logic          cmd_src_a2, cmd_src_b2, cmd_dst2;
    logic          in_valid2, in_ready2;
    logic [15:0]   in_data2;
    logic          out_valid2, out_ready2;
    logic [15:0]   out_data2;
    logic          busy2, done2;

    always #5 clk = ~clk;

    mau_stream #(.DIM(DIM), .EW(EW), .BANKS(BANKS)) u_dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_src_a(cmd_src_a), .cmd_src_b(cmd_src_b), .cmd_dst(cmd_dst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .done(done)
    );

    mau_stream #(.DIM(2), .EW(16), .BANKS(2)) u_dut2 (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid2), .cmd_ready(cmd_ready2), .cmd_op(cmd_op2),
        .cmd_src_a(cmd_src_a2), .cmd_src_b(cmd_src_b2), .cmd_dst(cmd_dst2),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2),
        .busy(busy2), .done(done2)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;
    int model  [BANKS][NEL];
    int ld_buf [NEL];

    always @(negedge clk) if (done) done_cnt++;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: observed %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Element rule straight from the operation definitions, on unbounded integers.
    function automatic int ref_op(input int op, input int a, input int b);
        int res;
        case (op)
            OP_ADD:  res = a + b;
            OP_SUB:  res = a - b;
            OP_MUL:  res = a * b;
            OP_SHL:  res = a << (b % EW);
            OP_COPY: res = a;
            default: res = 0;
        endcase
`ifdef MAU_STREAM_SAT_EN
        if ((op == OP_ADD || op == OP_MUL) && res > MAXV) res = MAXV;
        if (op == OP_SUB && res < 0) res = 0;
`endif
        return res & MAXV;
    endfunction

    task automatic send_cmd(input int op, input int a, input int b, input int d, output int waited);
        cmd_op    = op[2:0];
        cmd_src_a = a[1:0];
        cmd_src_b = b[1:0];
        cmd_dst   = d[1:0];
        cmd_valid = 1'b1;
        waited    = 0;
        while (!cmd_ready && waited < 100) begin
            tick();
            waited++;
        end
        if (!cmd_ready) check("cmd_accept_timeout", 0, 1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, output int edges);
        edges = 0;
        while (!done && edges < 100) begin
            tick();
            edges++;
        end
        check({tag, "_done_seen"}, done, 1);
        tick();
    endtask

    task automatic load_bank(input int d);
        int w, k, guard, base;
        logic rdy;
        base  = done_cnt;
        k     = 0;
        guard = 0;
        send_cmd(OP_LOAD, 0, 0, d, w);
        while (k < NEL && guard < 500) begin
            in_valid = 1'($urandom % 2);
            in_data  = EW'(ld_buf[k]);
            rdy      = in_ready;
            tick();
            guard++;
            if (in_valid && rdy) k++;
        end
        in_valid = 1'b0;
        check("load_count", k, NEL);
        check("load_done", done, 1);
        tick();
        check("load_done_once", done_cnt - base, 1);
        for (int i = 0; i < NEL; i++) model[d][i] = ld_buf[i];
    endtask

    task automatic fill_bank(input int d, input int val);
        for (int i = 0; i < NEL; i++) ld_buf[i] = val;
        load_bank(d);
    endtask

    task automatic store_bank(input int s, input string tag);
        int w, k, guard, base;
        logic v, stalled;
        logic [EW-1:0] dq, prev;
        base    = done_cnt;
        k       = 0;
        guard   = 0;
        stalled = 1'b0;
        prev    = '0;
        send_cmd(OP_STORE, s, 0, 0, w);
        check({tag, "_valid_after_accept"}, out_valid, 1);
        while (k < NEL && guard < 500) begin
            out_ready = 1'($urandom % 2);
            v  = out_valid;
            dq = out_data;
            if (stalled) check({tag, "_hold"}, {v, dq}, {1'b1, prev});
            if (v && out_ready) check({tag, "_data"}, dq, model[s][k]);
            stalled = v && !out_ready;
            prev    = dq;
            tick();
            guard++;
            if (v && out_ready) k++;
        end
        out_ready = 1'b0;
        check({tag, "_count"}, k, NEL);
        check({tag, "_done"}, done, 1);
        check({tag, "_valid_dropped"}, out_valid, 0);
        tick();
        check({tag, "_done_once"}, done_cnt - base, 1);
    endtask

    // Result is computed from the operands as they stood before the command.
    task automatic exec_op(input int op, input int a, input int b, input int d);
        int w, lat, base;
        int res[NEL];
        for (int i = 0; i < NEL; i++) res[i] = ref_op(op, model[a][i], model[b][i]);
        base = done_cnt;
        send_cmd(op, a, b, d, w);
        lat = 0;
        while (!done && lat < 100) begin
            tick();
            lat++;
        end
        // Accept edge is 0; done is visible in the cycle after edge DIM, i.e. cycle DIM+1.
        check("exec_done_latency", lat + 1, DIM + 1);
        tick();
        check("exec_ready_again", cmd_ready, 1);
        check("exec_done_once", done_cnt - base, 1);
        for (int i = 0; i < NEL; i++) model[d][i] = res[i];
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int w, base, lat;
        int res[NEL];
        int d2[4];

        cmd_valid = 0; cmd_op = 0; cmd_src_a = 0; cmd_src_b = 0; cmd_dst = 0;
        in_valid = 0; in_data = 0; out_ready = 0;
        cmd_valid2 = 0; cmd_op2 = 0; cmd_src_a2 = 0; cmd_src_b2 = 0; cmd_dst2 = 0;
        in_valid2 = 0; in_data2 = 0; out_ready2 = 0;
        for (int b = 0; b < BANKS; b++) for (int i = 0; i < NEL; i++) model[b][i] = 0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_out_data", out_data, 0);
        rst = 1'b1;
        tick();

        // Fill bank3, then abort a reload of it at k=5 with an async reset.
        for (int i = 0; i < NEL; i++) ld_buf[i] = $urandom_range(1, MAXV);
        load_bank(3);
        base = done_cnt;
        send_cmd(OP_LOAD, 0, 0, 3, w);
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = EW'($urandom);
            tick();
        end
        in_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_cmd_ready", cmd_ready, 1);
        check("abort_in_ready", in_ready, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        tick();
        check("abort_no_done", done_cnt - base, 0);
        for (int b = 0; b < BANKS; b++) for (int i = 0; i < NEL; i++) model[b][i] = 0;
        store_bank(3, "abort_store");

        for (int i = 0; i < NEL; i++) ld_buf[i] = i;
        load_bank(1);
        store_bank(1, "roundtrip");

        fill_bank(0, 200);
        fill_bank(1, 100);
        exec_op(OP_ADD, 0, 1, 2);
        store_bank(2, "add_wrap");

        fill_bank(0, 3);
        fill_bank(1, 5);
        exec_op(OP_SUB, 0, 1, 2);
        exec_op(OP_MUL, 0, 1, 3);
        store_bank(2, "sub_3_5");
        store_bank(3, "mul_3_5");

        fill_bank(0, 8'h81);
        fill_bank(1, 9);
        exec_op(OP_SHL, 0, 1, 2);
        store_bank(2, "shl_81_9");

        fill_bank(0, 16);
        fill_bank(1, 16);
        exec_op(OP_MUL, 0, 1, 2);
        store_bank(2, "mul_16_16");

        // In-place ADD with a COPY offered while the ADD is still running.
        for (int i = 0; i < NEL; i++) ld_buf[i] = i;
        load_bank(0);
        for (int i = 0; i < NEL; i++) res[i] = ref_op(OP_ADD, model[0][i], model[0][i]);
        send_cmd(OP_ADD, 0, 0, 0, w);
        for (int i = 0; i < NEL; i++) model[0][i] = res[i];
        send_cmd(OP_COPY, 0, 0, 3, w);
        check("busy_cmd_wait", w, DIM + 1);
        wait_done("alias_copy", lat);
        for (int i = 0; i < NEL; i++) model[3][i] = model[0][i];
        store_bank(0, "alias_add");
        store_bank(3, "alias_copy");

        for (int b = 0; b < BANKS; b++) begin
            for (int i = 0; i < NEL; i++) ld_buf[i] = $urandom_range(0, MAXV);
            load_bank(b);
        end
        for (int n = 0; n < 8; n++) begin
            exec_op($urandom_range(OP_ADD, OP_CLEAR), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 3));
        end
        for (int b = 0; b < BANKS; b++) store_bank(b, "random");

        // Parameter sweep instance: DIM=2, EW=16, BANKS=2.
        for (int i = 0; i < 4; i++) d2[i] = $urandom_range(0, 65535);
        check("p2_idle_ready", cmd_ready2, 1);
        cmd_op2 = 3'(OP_LOAD); cmd_dst2 = 1'b0; cmd_valid2 = 1'b1;
        tick();
        cmd_valid2 = 1'b0;
        in_valid2  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data2 = 16'(d2[i]);
            tick();
        end
        in_valid2 = 1'b0;
        check("p2_load_done", done2, 1);
        tick();
        cmd_op2 = 3'(OP_COPY); cmd_src_a2 = 1'b0; cmd_dst2 = 1'b1; cmd_valid2 = 1'b1;
        tick();
        cmd_valid2 = 1'b0;
        lat = 0;
        while (!done2 && lat < 50) begin
            tick();
            lat++;
        end
        check("p2_exec_latency", lat + 1, 3);
        tick();
        cmd_op2 = 3'(OP_STORE); cmd_src_a2 = 1'b1; cmd_valid2 = 1'b1;
        tick();
        cmd_valid2 = 1'b0;
        out_ready2 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("p2_store_valid", out_valid2, 1);
            check("p2_store_data", out_data2, d2[i]);
            tick();
        end
        out_ready2 = 1'b0;
        check("p2_store_done", done2, 1);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
